// File: rtl/dec_pkg.sv
// Shared decoder constants, the encoder state type and a one-hot helper.
package dec_pkg;

   localparam int N_REQ  = 8;
   localparam int CODE_W = 3;

   // IDLE means nothing is presented; PRESENT means code holds an unaccepted request
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } pe_state_t;

   // Binary index to one-hot vector (3-to-8 decode)
   function automatic logic [N_REQ-1:0] dec_onehot(input logic [CODE_W-1:0] c);
      logic [N_REQ-1:0] one;
      one        = {{(N_REQ-1){1'b0}}, 1'b1};
      dec_onehot = one << c;
   endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational priority pick over an 8-bit vector. With HIGH_FIRST=1 the
// highest set index wins, otherwise the lowest set index wins.
module prio_pick8
   import dec_pkg::*;
#(
   parameter int HIGH_FIRST = 1
) (
   input  logic [N_REQ-1:0]  vec,
   output logic [CODE_W-1:0] idx,
   output logic              hit
);

   logic [CODE_W-1:0] idx_s;

   // Scan toward the winning end so the last set bit seen is the winner
   always_comb begin
      idx_s = {CODE_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         if (HIGH_FIRST != 0) begin
            if (vec[i]) begin
               idx_s = CODE_W'(i);
            end else begin
               idx_s = idx_s;
            end
         end else begin
            if (vec[N_REQ-1-i]) begin
               idx_s = CODE_W'(N_REQ-1-i);
            end else begin
               idx_s = idx_s;
            end
         end
      end
   end

   assign idx = idx_s;
   assign hit = |vec;

endmodule

// File: rtl/prio_encoder8_seq.sv
// Sequential 8-input priority encoder with a valid/ack handshake. Requests
// that are not presented yet are remembered in pending; the winner of
// pending|req is loaded whenever the output slot is free or being accepted.
module prio_encoder8_seq
   import dec_pkg::*;
#(
   parameter int HIGH_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   input  logic              ack,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic [N_REQ-1:0]  pending,
   output logic              any
);

   pe_state_t         state_r;
   logic [CODE_W-1:0] code_r;
   logic [N_REQ-1:0]  pending_r;

   logic [N_REQ-1:0]  cand_s;
   logic [CODE_W-1:0] pick_idx_s;
   logic              pick_hit_s;
   logic              valid_s;
   logic              load_s;

   assign valid_s = (state_r == ST_PRESENT);
   assign cand_s  = pending_r | req;

   prio_pick8 #(
      .HIGH_FIRST (HIGH_FIRST)
   ) u_pick (
      .vec (cand_s),
      .idx (pick_idx_s),
      .hit (pick_hit_s)
   );

   // A new code may be loaded when something is waiting and the slot is free or accepted
   always_comb begin
      load_s = 1'b0;
      if (pick_hit_s && (!valid_s || ack)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Presentation state, code and pending capture; ack while idle is ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         code_r    <= {CODE_W{1'b0}};
         pending_r <= {N_REQ{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (load_s) begin
                  state_r   <= ST_PRESENT;
                  code_r    <= pick_idx_s;
                  pending_r <= cand_s & ~dec_onehot(pick_idx_s);
               end else begin
                  state_r   <= ST_IDLE;
                  code_r    <= {CODE_W{1'b0}};
                  pending_r <= cand_s;
               end
            end
            ST_PRESENT: begin
               if (load_s) begin
                  state_r   <= ST_PRESENT;
                  code_r    <= pick_idx_s;
                  pending_r <= cand_s & ~dec_onehot(pick_idx_s);
               end else if (ack) begin
                  state_r   <= ST_IDLE;
                  code_r    <= {CODE_W{1'b0}};
                  pending_r <= cand_s;
               end else begin
                  state_r   <= ST_PRESENT;
                  code_r    <= code_r;
                  pending_r <= cand_s;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               code_r    <= {CODE_W{1'b0}};
               pending_r <= {N_REQ{1'b0}};
            end
         endcase
      end
   end

   assign code    = code_r;
   assign valid   = valid_s;
   assign pending = pending_r;
   assign any     = valid_s | (|pending_r);

endmodule

// File: doc/prio_encoder8_seq.md
PRIO_ENCODER8_SEQ -- requirements
Module: prio_encoder8_seq

Interface
REQ-001 SHALL have parameter HIGH_FIRST, default 1, meaning: 1 gives index 7 the highest priority, 0 gives index 0 the highest priority.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req  input  8  one-cycle or level request lines, one per index 0..7.
REQ-005 SHALL have port ack  input  1  consumer accepts the presented code while valid=1.
REQ-006 SHALL have port code  output  3  binary index of the presented request.
REQ-007 SHALL have port valid  output  1  code holds a request that is not yet accepted.
REQ-008 SHALL have port pending  output  8  requests captured but not yet presented.
REQ-009 SHALL have port any  output  1  equals valid OR (pending != 0).

Function
REQ-010 SHALL define candidate set C = pending | req, evaluated every cycle.
REQ-011 SHALL define load = (C != 0) AND (valid=0 OR ack=1), evaluated every cycle.
REQ-012 SHALL have two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-013 SHALL move IDLE->PRESENT on load, PRESENT->PRESENT on ack with load, PRESENT->IDLE on ack without load, and otherwise hold the current state.
REQ-014 SHALL, on load, register code = the highest-priority index in C (per HIGH_FIRST) and set valid=1 at the same edge.
REQ-015 SHALL update pending at each edge to C with the loaded index bit cleared when load=1, and to C otherwise.
REQ-016 SHALL, for req asserted in cycle k with valid=0 and pending=0, present valid=1 with the matching code in cycle k+1, a latency of one clock.
REQ-017 SHALL hold code and valid stable while valid=1 and ack=0, regardless of req.
REQ-018 SHALL sustain a throughput of one accepted code per cycle when ack is held high and C is nonzero.
REQ-019 SHALL merge a req for an index already pending into that pending bit, so the index is presented once.
REQ-020 SHALL set the pending bit again for a req on the index currently presented, so the index is presented a second time later.
REQ-021 SHALL keep valid=0 when ack=1 arrives with valid=0; ack has no effect in that case.
REQ-022 SHALL drive code=0 whenever valid=0.

Reset
REQ-023 SHALL, on rst assertion and independent of clk, force valid=0, code=0, pending=0, and any=0.
REQ-024 SHALL drop all captured and in-flight requests when rst is asserted mid-operation.
REQ-025 SHALL ignore req in every cycle in which rst is high.
REQ-026 SHALL evaluate the first load on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL take N_REQ=8 and CODE_W=3 as constants from shared package dec_pkg, which the codebase's decoders also use.
REQ-028 SHALL place the priority selection in one combinational sub-module, prio_pick8, with inputs vec[7:0] and HIGH_FIRST and outputs idx[2:0] and hit.
REQ-029 SHALL hold state only in the code, valid, and pending registers.

Verification
REQ-030 SHALL check single request: req=8'h20 for one cycle with ack=0 -> next cycle valid=1, code=5, pending=0.
REQ-031 SHALL check priority order: req=8'h81 for one cycle with HIGH_FIRST=1 and ack=1 -> code=7 then code=0 on consecutive cycles, then valid=0.
REQ-032 SHALL check hold under backpressure: present code=3 with ack=0 for 5 cycles while req=8'h80 pulses -> code stays 3, pending=8'h80; after ack, code=7.
REQ-033 SHALL check re-request: req=8'h04 while code=2 is presented -> after ack, code=2 is presented again.
REQ-034 SHALL check reset mid-operation: pending=8'hF0 and valid=1, then rst pulses between clock edges -> valid=0, code=0, pending=0 immediately, with no codes presented afterwards.
REQ-035 SHALL check the complement direction: feed each code into the existing 3-to-8 decoder -> its one-hot output equals the original single-bit req for all 8 indices.
